// File: rtl/fwd_ctrl_pkg.sv
// Shared constants for the forwarding/hazard controller: forward-select encodings,
// register index width and the shadow-pipeline entry layout.
package fwd_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             use_rs;
        logic             use_rt;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             is_load;
        logic             is_muldiv;
    } stage_t;

endpackage

// File: rtl/fwd_ctrl_if.sv
// ID-stage instruction fields in, forward selects and pipeline controls out.
interface fwd_ctrl_if;
    import fwd_ctrl_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_is_load;
    logic             id_is_muldiv;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic             ex_hold;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_reg_write, id_is_load, id_is_muldiv, flush,
        input  fwd_a_sel, fwd_b_sel, stall, ex_hold
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_reg_write, id_is_load, id_is_muldiv, flush,
        output fwd_a_sel, fwd_b_sel, stall, ex_hold
    );

endinterface

// File: rtl/fwd_ctrl_match.sv
// One source-register versus pipeline-stage producer comparison; r0 never matches.
module fwd_match
    import fwd_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic             valid_i,
    input  logic             reg_write_i,
    input  logic [REG_W-1:0] rd_i,
    output logic             hit_o
);

    assign hit_o = valid_i && reg_write_i && (rd_i == src_i) && (src_i != '0);

endmodule

// File: rtl/fwd_ctrl.sv
// Operand forwarding and load-use/multi-cycle hazard control over a shadow EX/MEM/WB pipeline.
// Define FWD_MULDIV_EN to build the multi-cycle mul/div busy counter and ex_hold.
module fwd_ctrl
    import fwd_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4
) (
    input logic       clk,
    input logic       rst_n,
    fwd_ctrl_if.slave bus
);

    stage_t   id_s;
    stage_t   ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    fwd_sel_e a_sel, b_sel;
    logic     hit_a_mem, hit_a_wb, hit_b_mem, hit_b_wb, hit_id_rs, hit_id_rt;
    logic     load_use, stall, ex_hold;

    always_comb begin
        id_s           = '0;
        id_s.valid     = bus.id_valid & ~bus.flush;
        id_s.rs        = bus.id_rs;
        id_s.rt        = bus.id_rt;
        id_s.use_rs    = bus.id_use_rs;
        id_s.use_rt    = bus.id_use_rt;
        id_s.rd        = bus.id_rd;
        id_s.reg_write = bus.id_reg_write;
        id_s.is_load   = bus.id_is_load;
        id_s.is_muldiv = bus.id_is_muldiv;
    end

    fwd_match u_a_mem (.src_i(ex_q.rs), .valid_i(mem_q.valid), .reg_write_i(mem_q.reg_write), .rd_i(mem_q.rd), .hit_o(hit_a_mem));
    fwd_match u_a_wb  (.src_i(ex_q.rs), .valid_i(wb_q.valid),  .reg_write_i(wb_q.reg_write),  .rd_i(wb_q.rd),  .hit_o(hit_a_wb));
    fwd_match u_b_mem (.src_i(ex_q.rt), .valid_i(mem_q.valid), .reg_write_i(mem_q.reg_write), .rd_i(mem_q.rd), .hit_o(hit_b_mem));
    fwd_match u_b_wb  (.src_i(ex_q.rt), .valid_i(wb_q.valid),  .reg_write_i(wb_q.reg_write),  .rd_i(wb_q.rd),  .hit_o(hit_b_wb));
    fwd_match u_id_rs (.src_i(bus.id_rs), .valid_i(ex_q.valid), .reg_write_i(ex_q.reg_write), .rd_i(ex_q.rd), .hit_o(hit_id_rs));
    fwd_match u_id_rt (.src_i(bus.id_rt), .valid_i(ex_q.valid), .reg_write_i(ex_q.reg_write), .rd_i(ex_q.rd), .hit_o(hit_id_rt));

    // A load sitting in MEM has no data yet, so it falls through to the WB check.
    always_comb begin
        a_sel = FWD_RF;
        if (ex_q.valid && ex_q.use_rs) begin
            if (hit_a_mem && !mem_q.is_load) a_sel = FWD_MEM;
            else if (hit_a_wb)               a_sel = FWD_WB;
        end
        b_sel = FWD_RF;
        if (ex_q.valid && ex_q.use_rt) begin
            if (hit_b_mem && !mem_q.is_load) b_sel = FWD_MEM;
            else if (hit_b_wb)               b_sel = FWD_WB;
        end
    end

    assign load_use = bus.id_valid && !bus.flush && ex_q.is_load &&
                      ((hit_id_rs && bus.id_use_rs) || (hit_id_rt && bus.id_use_rt));
    assign stall    = load_use || ex_hold;

`ifdef FWD_MULDIV_EN
    logic [3:0] busy_q, busy_d;

    // Counter arms on the cycle a mul/div is captured into EX, so EX occupancy is busy + 1.
    always_comb begin
        busy_d = busy_q;
        if (busy_q != '0)
            busy_d = busy_q - 4'd1;
        else if (!stall && id_s.valid && id_s.is_muldiv)
            busy_d = 4'(MULDIV_CYCLES - 1);
    end

    assign ex_hold = (busy_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end
`else
    assign ex_hold = 1'b0;
`endif

    always_comb begin
        wb_d = mem_q;
        if (ex_hold) begin
            ex_d  = ex_q;
            mem_d = '0;
        end else if (stall) begin
            ex_d  = '0;
            mem_d = ex_q;
        end else begin
            ex_d  = id_s;
            mem_d = ex_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ex_q.is_muldiv, mem_q.rs, mem_q.rt, mem_q.use_rs, mem_q.use_rt,
                           mem_q.is_muldiv, wb_q.rs, wb_q.rt, wb_q.use_rs, wb_q.use_rt,
                           wb_q.is_load, wb_q.is_muldiv, 4'(MULDIV_CYCLES)};

    assign bus.fwd_a_sel = a_sel;
    assign bus.fwd_b_sel = b_sel;
    assign bus.stall     = stall;
    assign bus.ex_hold   = ex_hold;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed scoreboard bench for fwd_ctrl; multi-cycle cases build only with FWD_MULDIV_EN.
module tb_fwd_ctrl;
    import fwd_ctrl_pkg::*;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       md;
    } ins_t;

    typedef struct {
        string      tag;
        logic [1:0] a;
        logic [1:0] b;
        logic       st;
        logic       hd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    fwd_ctrl_if bus ();

    fwd_ctrl #(.MULDIV_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    localparam ins_t NOP = '0;

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return '{v:1'b1, rs:rs, rt:rt, urs:1'b1, urt:1'b1, rd:rd, rw:1'b1, ld:1'b0, md:1'b0};
    endfunction

    function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] rs);
        return '{v:1'b1, rs:rs, rt:5'd0, urs:1'b1, urt:1'b0, rd:rd, rw:1'b1, ld:1'b1, md:1'b0};
    endfunction

    function automatic ins_t mul(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return '{v:1'b1, rs:rs, rt:rt, urs:1'b1, urt:1'b1, rd:rd, rw:1'b1, ld:1'b0, md:1'b1};
    endfunction

    task automatic chk(input string name, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, expv);
        end
    endtask

    task automatic drive(input ins_t i, input logic fl);
        bus.id_valid     = i.v;
        bus.id_rs        = i.rs;
        bus.id_rt        = i.rt;
        bus.id_use_rs    = i.urs;
        bus.id_use_rt    = i.urt;
        bus.id_rd        = i.rd;
        bus.id_reg_write = i.rw;
        bus.id_is_load   = i.ld;
        bus.id_is_muldiv = i.md;
        bus.flush        = fl;
    endtask

    task automatic observe();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".a"},     bus.fwd_a_sel,       e.a);
        chk({e.tag, ".b"},     bus.fwd_b_sel,       e.b);
        chk({e.tag, ".stall"}, {1'b0, bus.stall},   {1'b0, e.st});
        chk({e.tag, ".hold"},  {1'b0, bus.ex_hold}, {1'b0, e.hd});
    endtask

    // Drive one ID slot at the falling edge; expected outputs describe the same cycle.
    task automatic cyc(input ins_t i, input logic fl, input string tag,
                       input logic [1:0] ea, input logic [1:0] eb, input logic es, input logic eh);
        @(negedge clk);
        drive(i, fl);
        sb.push_back('{tag:tag, a:ea, b:eb, st:es, hd:eh});
        #2;
        observe();
    endtask

    task automatic reset_now(input string tag);
        #1 rst_n = 1'b0;
        sb.push_back('{tag:tag, a:2'd0, b:2'd0, st:1'b0, hd:1'b0});
        #1;
        observe();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(NOP, 1'b0);

        cyc(lw(2, 20), 1'b0, "rst_hold0", 0, 0, 0, 0);
        cyc(alu(6, 2, 2), 1'b0, "rst_hold1", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(NOP, 1'b0);

        cyc(alu(3, 20, 21), 1'b0, "b2b_prod",  0, 0, 0, 0);
        cyc(alu(4, 3, 5),   1'b0, "b2b_cons",  0, 0, 0, 0);
        cyc(NOP,            1'b0, "b2b_fwd",   1, 0, 0, 0);
        cyc(NOP,            1'b0, "b2b_drain", 0, 0, 0, 0);

        cyc(alu(3, 20, 21), 1'b0, "d2_prod",  0, 0, 0, 0);
        cyc(alu(7, 22, 23), 1'b0, "d2_indep", 0, 0, 0, 0);
        cyc(alu(8, 3, 24),  1'b0, "d2_cons",  0, 0, 0, 0);
        cyc(NOP,            1'b0, "d2_fwd",   2, 0, 0, 0);
        cyc(NOP,            1'b0, "d2_drain", 0, 0, 0, 0);

        cyc(alu(3, 20, 21), 1'b0, "dbl_p1",   0, 0, 0, 0);
        cyc(alu(3, 22, 23), 1'b0, "dbl_p2",   0, 0, 0, 0);
        cyc(alu(9, 3, 3),   1'b0, "dbl_cons", 0, 0, 0, 0);
        cyc(NOP,            1'b0, "dbl_fwd",  1, 1, 0, 0);

        cyc(alu(0, 20, 21), 1'b0, "r0_prod",  0, 0, 0, 0);
        cyc(alu(10, 0, 0),  1'b0, "r0_cons",  0, 0, 0, 0);
        cyc(NOP,            1'b0, "r0_fwd",   0, 0, 0, 0);
        cyc(NOP,            1'b0, "r0_drain", 0, 0, 0, 0);

        cyc(lw(2, 20),    1'b0, "lu_load",   0, 0, 0, 0);
        cyc(alu(6, 2, 2), 1'b0, "lu_stall",  0, 0, 1, 0);
        cyc(alu(6, 2, 2), 1'b0, "lu_bubble", 0, 0, 0, 0);
        cyc(NOP,          1'b0, "lu_fwd",    2, 2, 0, 0);
        cyc(NOP,          1'b0, "lu_drain",  0, 0, 0, 0);

        cyc(lw(2, 20),     1'b0, "lurt_load",   0, 0, 0, 0);
        cyc(alu(6, 20, 2), 1'b0, "lurt_stall",  0, 0, 1, 0);
        cyc(alu(6, 20, 2), 1'b0, "lurt_bubble", 0, 0, 0, 0);
        cyc(NOP,           1'b0, "lurt_fwd",    0, 2, 0, 0);
        cyc(NOP,           1'b0, "lurt_drain",  0, 0, 0, 0);

        cyc(lw(2, 20),    1'b0, "luf_load",     0, 0, 0, 0);
        cyc(alu(6, 2, 2), 1'b1, "luf_flush",    0, 0, 0, 0);
        cyc(NOP,          1'b0, "luf_squashed", 0, 0, 0, 0);
        cyc(NOP,          1'b0, "luf_drain",    0, 0, 0, 0);

        cyc(lw(2, 20),    1'b0, "rs_load",  0, 0, 0, 0);
        cyc(alu(6, 2, 2), 1'b0, "rs_stall", 0, 0, 1, 0);
        reset_now("rst_mid_stall");
        cyc(alu(3, 20, 21), 1'b0, "post_prod", 0, 0, 0, 0);
        cyc(alu(4, 3, 3),   1'b0, "post_cons", 0, 0, 0, 0);
        cyc(NOP,            1'b0, "post_fwd",  1, 1, 0, 0);
        cyc(NOP,            1'b0, "post_drain", 0, 0, 0, 0);

`ifdef FWD_MULDIV_EN
        cyc(mul(9, 20, 21),  1'b0, "mul_issue",   0, 0, 0, 0);
        cyc(alu(10, 9, 21),  1'b0, "mul_hold1",   0, 0, 1, 1);
        cyc(alu(10, 9, 21),  1'b1, "mul_hold2_fl", 0, 0, 1, 1);
        cyc(alu(10, 9, 21),  1'b0, "mul_hold3",   0, 0, 1, 1);
        cyc(alu(10, 9, 21),  1'b0, "mul_release", 0, 0, 0, 0);
        cyc(NOP,             1'b0, "mul_fwd",     1, 0, 0, 0);
        cyc(NOP,             1'b0, "mul_drain",   0, 0, 0, 0);

        cyc(mul(9, 20, 21),  1'b0, "mr_issue", 0, 0, 0, 0);
        cyc(alu(10, 9, 21),  1'b0, "mr_hold",  0, 0, 1, 1);
        reset_now("rst_mid_mul");
        cyc(alu(10, 9, 21),  1'b0, "mr_after", 0, 0, 0, 0);
        cyc(alu(11, 10, 20), 1'b0, "mr_cons",  0, 0, 0, 0);
        cyc(NOP,             1'b0, "mr_fwd",   1, 0, 0, 0);
`else
        cyc(mul(9, 20, 21),  1'b0, "nomd_issue",  0, 0, 0, 0);
        cyc(alu(10, 9, 21),  1'b0, "nomd_nohold", 0, 0, 0, 0);
        cyc(NOP,             1'b0, "nomd_fwd",    1, 0, 0, 0);
`endif

        chk("sb_empty", 2'(sb.size()), 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_ctrl.md
FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Parameter: MULDIV_CYCLES, 4, EX occupancy in cycles of a multi-cycle mul/div op (valid range 2..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_valid  input  1  ID holds a real instruction.
REQ-005 id_rs, id_rt  input  5 each  ID source register numbers.
REQ-006 id_use_rs, id_use_rt  input  1 each  ID instruction reads rs/rt.
REQ-007 id_rd  input  5  ID destination register.
REQ-008 id_reg_write, id_is_load  input  1 each  ID writes rd / is a load.
REQ-009 id_is_muldiv  input  1  ID is multi-cycle (used only with FWD_MULDIV_EN).
REQ-010 flush  input  1  squash the ID instruction this cycle.
REQ-011 fwd_a_sel, fwd_b_sel  output  2 each  select for the 3-input EX operand data mux: 0 regfile, 1 EX/MEM result, 2 MEM/WB result.
REQ-012 stall  output  1  freeze PC and IF/ID.
REQ-013 ex_hold  output  1  freeze ID/EX and the EX unit; MEM receives a bubble.

Function
REQ-014 Shadow pipeline: three registered entries EX, MEM and WB, each {valid, rs, rt, use_rs, use_rt, rd, reg_write, is_load, is_muldiv}.
REQ-015 Normal advance (stall=0, ex_hold=0): EX<=ID fields with valid=id_valid&~flush; MEM<=EX; WB<=MEM.
REQ-016 stall=1, ex_hold=0: EX<=bubble (valid=0); MEM<=EX; WB<=MEM.
REQ-017 ex_hold=1: EX held; MEM<=bubble; WB<=MEM.
REQ-018 Match(src, stage) is true when: stage valid; stage reg_write=1; stage rd==src; src!=0. Register 0 never matches.
REQ-019 fwd_a_sel is combinational from registered state:
 - 0 when EX invalid or EX use_rs=0.
 - 1 when Match(EX.rs, MEM) and MEM is_load=0.
 - else 2 when Match(EX.rs, WB).
 - else 0.
 - MEM has priority over WB (youngest wins).
REQ-020 fwd_b_sel: identical rule with rt/use_rt.
REQ-021 A load in MEM never selects 1; its consumer was separated by the load-use stall and forwards from WB.
REQ-022 Load-use hazard condition: id_valid; EX is_load; Match(id_rs, EX) with id_use_rs, or Match(id_rt, EX) with id_use_rt.
REQ-023 A load-use hazard asserts stall combinationally for exactly one cycle per hazard.
REQ-024 flush=1 forces stall=0 from the load-use hazard (the squashed instruction is not protected).
REQ-025 Latency: forward selects are valid in the same cycle the consumer is in EX; zero added cycles except for stalls.

Reset
REQ-026 rst_n=0 asynchronously clears the valid bits of all shadow entries and the busy counter.
REQ-027 Outputs during and after reset: fwd_a_sel=0, fwd_b_sel=0, stall=0, ex_hold=0.
REQ-028 Reset mid-stall or mid-muldiv abandons the operation; no residual hold after release.

Configuration
REQ-029 Macro FWD_MULDIV_EN.
REQ-030 Defined: when a valid EX entry with is_muldiv=1 is first captured, the busy counter loads MULDIV_CYCLES-1.
REQ-031 Defined: while the busy counter is nonzero, ex_hold=1 and stall=1, and the counter decrements each cycle.
REQ-032 Defined: the instruction leaves EX on the cycle the counter reaches 0; total EX occupancy equals MULDIV_CYCLES.
REQ-033 Defined: flush during busy squashes only ID and does not shorten the hold.
REQ-034 Not defined: id_is_muldiv is ignored, no counter is built, and ex_hold is tied to 0.

Structure
REQ-035 The shared constants package holds the forward-select encodings (FWD_RF=0, FWD_MEM=1, FWD_WB=2) and the register-index width (5), reused by the EX mux instantiation.
REQ-036 A sub-module fwd_match performs one comparison (src, stage fields -> hit); it is instantiated for each source/stage pair.

Verification
REQ-037 Back-to-back dependency: add r3 then add r4,r3,r5 -> fwd_a_sel=1 when the consumer is in EX; stall stays 0.
REQ-038 Distance-2 dependency: producer r3, independent op, consumer r3 -> fwd_a_sel=2.
REQ-039 Double hit: MEM and WB both write r3 -> sel=1. Destination r0 -> sel=0.
REQ-040 Load-use: lw r2 then add r6,r2,r2 -> stall=1 for one cycle, then fwd_a_sel=fwd_b_sel=2; the same case with flush=1 -> stall=0.
REQ-041 FWD_MULDIV_EN, MULDIV_CYCLES=4: mul in EX -> ex_hold=stall=1 for 3 cycles, then release; a follower depending on the mul result gets sel=1.
REQ-042 Async reset asserted during muldiv hold -> all outputs 0 immediately; normal forwarding resumes after release.
